divide_unit: RTL and testbench

- Iterative RV64M integer divider: DIV, DIVU, REM and REMU, plus the 32-bit W forms when configured.
- Sits in the execute stage. It takes rs1/rs2 operands read from `register_file` and returns the result with its rd address to writeback, which drives the register file write port (`rd_addr_i`/`wr_en_i`/`wr_data_i`).
- Uses a radix-2 restoring algorithm, one quotient bit per cycle, with valid/ready handshakes on both sides.

---
 rtl/divide_unit.sv | 190 +++++++++++++++++++
 tb/tb_divide_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/divide_unit.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU.
// Define DIVIDE_UNIT_WORD_OPS_EN to honour word_i (32-bit W forms, sign-extended results).
module divide_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);

  typedef enum logic [1:0] {StIdle, StDivide, StDone} state_e;

  state_e            r_state, w_state_nx;
  logic              r_is_rem;
  logic              r_word;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [5:0]        r_cnt;
  logic [XLEN-1:0]   r_divisor;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd_addr;

  logic              w_word;
  logic              w_signed;
  logic              w_accept;
  logic              w_last;
  logic              w_sa;
  logic              w_sb;
  logic              w_div_zero;
  logic              w_ovf;
  logic [XLEN-1:0]   w_a_ext;
  logic [XLEN-1:0]   w_b_ext;
  logic [XLEN-1:0]   w_a_abs;
  logic [XLEN-1:0]   w_b_abs;
  logic [XLEN-1:0]   w_quo_init;
  logic [XLEN-1:0]   w_spec_raw;
  logic [XLEN-1:0]   w_spec_res;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_diff;
  logic [XLEN-1:0]   w_rem_nx;
  logic [XLEN-1:0]   w_quo_nx;
  logic [XLEN-1:0]   w_q_fix;
  logic [XLEN-1:0]   w_r_fix;
  logic [XLEN-1:0]   w_fin;
  logic [XLEN-1:0]   w_fin_ext;

`ifdef DIVIDE_UNIT_WORD_OPS_EN
  assign w_word = word_i;
`else
  logic w_unused_word;
  assign w_unused_word = word_i;
  assign w_word        = 1'b0;
`endif

  assign ready_o   = (r_state == StIdle);
  assign valid_o   = (r_state == StDone);
  assign result_o  = r_result;
  assign rd_addr_o = r_rd_addr;

  assign w_signed = ~op_i[0];
  assign w_accept = valid_i && ready_o && !flush_i && !reset;
  assign w_last   = r_word ? (r_cnt == 6'd31) : (r_cnt == 6'd63);

  // Operand conditioning: W forms view the low 32 bits as a signed or unsigned value.
  always_comb begin
    w_a_ext = rs1_data_i;
    w_b_ext = rs2_data_i;
    if (w_word) begin
      w_a_ext = w_signed ? {{32{rs1_data_i[31]}}, rs1_data_i[31:0]} : {32'b0, rs1_data_i[31:0]};
      w_b_ext = w_signed ? {{32{rs2_data_i[31]}}, rs2_data_i[31:0]} : {32'b0, rs2_data_i[31:0]};
    end
    w_sa    = w_signed & w_a_ext[XLEN-1];
    w_sb    = w_signed & w_b_ext[XLEN-1];
    w_a_abs = w_sa ? (~w_a_ext + 1'b1) : w_a_ext;
    w_b_abs = w_sb ? (~w_b_ext + 1'b1) : w_b_ext;
    // Left-align a 32-bit dividend so 32 shifts consume exactly its bits.
    w_quo_init = w_word ? {w_a_abs[31:0], 32'b0} : w_a_abs;

    w_div_zero = (w_b_ext == '0);
    if (w_word) begin
      w_ovf = w_signed && (rs1_data_i[31:0] == 32'h8000_0000) &&
              (rs2_data_i[31:0] == 32'hFFFF_FFFF);
    end else begin
      w_ovf = w_signed && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) &&
              (rs2_data_i == '1);
    end

    w_spec_raw = '0;
    if (w_div_zero) begin
      w_spec_raw = op_i[1] ? rs1_data_i : '1;
    end else if (w_ovf) begin
      w_spec_raw = op_i[1] ? '0 : rs1_data_i;
    end
    w_spec_res = w_word ? {{32{w_spec_raw[31]}}, w_spec_raw[31:0]} : w_spec_raw;
  end

  // One restoring step plus sign fix-up of the final step's outputs.
  always_comb begin
    w_shift   = {r_rem, r_quo[XLEN-1]};
    w_diff    = w_shift - {1'b0, r_divisor};
    w_rem_nx  = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
    w_quo_nx  = {r_quo[XLEN-2:0], ~w_diff[XLEN]};
    w_q_fix   = r_neg_q ? (~w_quo_nx + 1'b1) : w_quo_nx;
    w_r_fix   = r_neg_r ? (~w_rem_nx + 1'b1) : w_rem_nx;
    w_fin     = r_is_rem ? w_r_fix : w_q_fix;
    w_fin_ext = r_word ? {{32{w_fin[31]}}, w_fin[31:0]} : w_fin;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_nx = (w_div_zero || w_ovf) ? StDone : StDivide;
        end
      end
      StDivide: begin
        if (w_last) begin
          w_state_nx = StDone;
        end
      end
      StDone: begin
        if (ready_i) begin
          w_state_nx = StIdle;
        end
      end
      default: w_state_nx = StIdle;
    endcase
    if (flush_i) begin
      w_state_nx = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_rem  <= 1'b0;
      r_word    <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_cnt     <= '0;
      r_divisor <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_result  <= '0;
      r_rd_addr <= '0;
    end else if (w_accept) begin
      r_is_rem  <= op_i[1];
      r_word    <= w_word;
      r_neg_q   <= w_sa ^ w_sb;
      r_neg_r   <= w_sa;
      r_cnt     <= '0;
      r_divisor <= w_b_abs;
      r_rem     <= '0;
      r_quo     <= w_quo_init;
      r_rd_addr <= rd_addr_i;
      if (w_div_zero || w_ovf) begin
        r_result <= w_spec_res;
      end
    end else if (r_state == StDivide && !flush_i) begin
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
      r_cnt <= r_cnt + 6'd1;
      if (w_last) begin
        r_result <= w_fin_ext;
      end
    end
  end

endmodule

// File: tb/tb_divide_unit.sv
// Directed self-checking bench for divide_unit; W-form vectors depend on
// DIVIDE_UNIT_WORD_OPS_EN.
module tb_divide_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  op_i;
  logic        word_i;
  logic [63:0] rs1_data_i;
  logic [63:0] rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        valid_o;
  logic        ready_i;
  logic [63:0] result_o;
  logic [4:0]  rd_addr_o;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [1:0] OpDiv  = 2'b00;
  localparam logic [1:0] OpDivu = 2'b01;
  localparam logic [1:0] OpRem  = 2'b10;
  localparam logic [1:0] OpRemu = 2'b11;

  divide_unit #(.XLEN(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .op_i       (op_i),
    .word_i     (word_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .rd_addr_i  (rd_addr_i),
    .flush_i    (flush_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .result_o   (result_o),
    .rd_addr_o  (rd_addr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd);
    @(negedge clk);
    op_i       = op;
    word_i     = w;
    rs1_data_i = a;
    rs2_data_i = b;
    rd_addr_i  = rd;
    valid_i    = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  // Issue one op, measure edges until valid_o, optionally stall, then consume.
  task automatic run_op(input string tag, input logic [1:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                        input logic [63:0] exp, input int exp_lat, input int hold);
    int lat;
    check({tag, "_ready_before"}, {63'b0, ready_o}, 64'd1);
    issue(op, w, a, b, rd);
    lat = 0;
    while (!valid_o && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, result_o, exp);
    check({tag, "_rd"}, {59'b0, rd_addr_o}, {59'b0, rd});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, {63'b0, valid_o}, 64'd1);
      check({tag, "_hold_result"}, result_o, exp);
      check({tag, "_hold_rd"}, {59'b0, rd_addr_o}, {59'b0, rd});
      check({tag, "_hold_ready"}, {63'b0, ready_o}, 64'd0);
    end
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    check({tag, "_consumed"}, {63'b0, valid_o}, 64'd0);
    check({tag, "_ready_after"}, {63'b0, ready_o}, 64'd1);
  endtask

  initial begin
    reset      = 1'b1;
    valid_i    = 1'b0;
    op_i       = 2'b00;
    word_i     = 1'b0;
    rs1_data_i = '0;
    rs2_data_i = '0;
    rd_addr_i  = '0;
    flush_i    = 1'b0;
    ready_i    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_ready", {63'b0, ready_o}, 64'd1);
    check("reset_valid", {63'b0, valid_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_rd", {59'b0, rd_addr_o}, 64'd0);

    run_op("divu_100_7", OpDivu, 1'b0, 64'd100, 64'd7, 5'd3, 64'd14, 64, 0);
    run_op("remu_100_7", OpRemu, 1'b0, 64'd100, 64'd7, 5'd4, 64'd2, 64, 0);
    run_op("div_m7_2", OpDiv, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd5,
           64'hFFFF_FFFF_FFFF_FFFD, 64, 0);
    run_op("rem_m7_2", OpRem, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6,
           64'hFFFF_FFFF_FFFF_FFFF, 64, 0);
    run_op("div_7_m2", OpDiv, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd7,
           64'hFFFF_FFFF_FFFF_FFFD, 64, 0);
    run_op("rem_7_m2", OpRem, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd8, 64'd1, 64, 0);
    run_op("div_5_0", OpDiv, 1'b0, 64'd5, 64'd0, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    run_op("rem_5_0", OpRem, 1'b0, 64'd5, 64'd0, 5'd10, 64'd5, 0, 0);
    run_op("div_ovf", OpDiv, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11,
           64'h8000_0000_0000_0000, 0, 0);
    run_op("rem_ovf", OpRem, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12,
           64'd0, 0, 0);
    run_op("divu_big", OpDivu, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 5'd0,
           64'h0FFF_FFFF_FFFF_FFFF, 64, 0);
    run_op("divu_hold", OpDivu, 1'b0, 64'd1000, 64'd10, 5'd13, 64'd100, 64, 10);

`ifdef DIVIDE_UNIT_WORD_OPS_EN
    run_op("divw", OpDiv, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd14,
           64'hFFFF_FFFF_FFFF_FFFD, 32, 0);
    run_op("divuw", OpDivu, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd15,
           64'h0000_0000_7FFF_FFFC, 32, 0);
    run_op("divw_0", OpDiv, 1'b1, 64'h1234_0000_0000_0005, 64'hFFFF_FFFF_0000_0000, 5'd16,
           64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
`else
    run_op("div_word_ignored", OpDiv, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd14,
           64'h0000_0000_7FFF_FFFC, 64, 0);
`endif

    // Flush at DIVIDE iteration 20: unit returns to idle and never raises valid_o.
    issue(OpDivu, 1'b0, 64'd100, 64'd7, 5'd17);
    repeat (19) @(posedge clk);
    #1;
    check("flush_busy", {63'b0, ready_o}, 64'd0);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    check("flush_ready", {63'b0, ready_o}, 64'd1);
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1;
      if (valid_o) check("flush_valid", {63'b0, valid_o}, 64'd0);
    end
    check("flush_valid_end", {63'b0, valid_o}, 64'd0);

    // valid_i with flush_i is not an accept; a divide-by-zero would show valid_o at once.
    @(negedge clk);
    op_i       = OpDiv;
    rs1_data_i = 64'd5;
    rs2_data_i = 64'd0;
    valid_i    = 1'b1;
    flush_i    = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    flush_i = 1'b0;
    check("flush_accept_valid", {63'b0, valid_o}, 64'd0);
    check("flush_accept_ready", {63'b0, ready_o}, 64'd1);

    // Reset in the middle of a divide.
    issue(OpDiv, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd21);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midreset_ready", {63'b0, ready_o}, 64'd1);
    check("midreset_valid", {63'b0, valid_o}, 64'd0);
    check("midreset_result", result_o, 64'd0);
    check("midreset_rd", {59'b0, rd_addr_o}, 64'd0);

    run_op("post_reset_rem", OpRem, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd22, 64'd2, 64, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
